// File: rtl/spi_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_rx
// Purpose  : SPI (mode 0, MSB first) frame receiver. Synchronises the MCU pins
//            into clk, assembles fixed-length frames, checks their length at
//            chip-select release and queues good frames in a FIFO that is
//            read through a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_rx #(
  parameter int PACKET_BYTES = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_STAGES  = 2,
  localparam int c_FW = 8 * PACKET_BYTES,
  localparam int c_LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sck,
  input  logic            sdi,
  input  logic            cs,
  output logic [c_FW-1:0] frame_data,
  output logic            frame_valid,
  input  logic            frame_ready,
  output logic            frame_err,
  output logic            overflow,
  output logic [c_LW-1:0] fifo_level,
  output logic            busy
);

  // Bit counter must hold FW+1 so that overlength frames stay distinguishable.
  localparam int c_CW = $clog2(c_FW + 2);
  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(c_FW);
  localparam logic [c_CW-1:0] c_CNT_MAX  = c_CW'(c_FW + 1);
  localparam logic [c_LW-1:0] c_DEPTH    = c_LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sck_prev;

  state_t                 r_state;
  logic [c_FW-1:0]        r_shift;
  logic [c_CW-1:0]        r_bit_cnt;
  logic                   r_frame_err;

  logic [c_FW-1:0]        r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]        r_wr_ptr;
  logic [c_PW-1:0]        r_rd_ptr;
  logic [c_LW-1:0]        r_level;
  logic                   r_overflow;

  logic w_sck;
  logic w_sdi;
  logic w_cs;
  logic w_sck_rise;
  logic w_valid;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_push_ok;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_prev;

  // Pin synchronisers; reset loads the idle bus state so no false edge or
  // false chip-select is seen right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_sync <= '0;
      r_sdi_sync <= '0;
      r_cs_sync  <= '1;
      r_sck_prev <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_sck_prev <= w_sck;
    end
  end

  // Frame assembly FSM: shift while selected, judge length for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_cs) begin
            r_state   <= S_SHIFT;
            r_bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (w_sck_rise) begin
            r_shift <= {r_shift[c_FW-2:0], w_sdi};
            if (r_bit_cnt != c_CNT_MAX) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          if (w_cs) begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_bit_cnt != c_CNT_FULL) begin
            r_frame_err <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_push    = (r_state == S_CHECK) && (r_bit_cnt == c_CNT_FULL);
  assign w_valid   = (r_level != '0);
  assign w_full    = (r_level == c_DEPTH);
  assign w_pop     = w_valid & frame_ready;
  assign w_push_ok = w_push & (~w_full | w_pop);

  // FIFO storage; contents need no reset since the level gates visibility.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign frame_data  = w_valid ? r_mem[r_rd_ptr] : '0;
  assign frame_valid = w_valid;
  assign fifo_level  = r_level;
  assign frame_err   = r_frame_err;
  assign overflow    = r_overflow;
  assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_frame_rx
// Purpose  : Directed self-checking bench for spi_frame_rx (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_frame_rx;

  logic        clk;
  logic        reset;
  logic        sck;
  logic        sdi;
  logic        cs;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        frame_err;
  logic        overflow;
  logic [2:0]  fifo_level;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;

  spi_frame_rx #(
    .PACKET_BYTES(2),
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .sdi        (sdi),
    .cs         (cs),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every cycle in which frame_err is high.
  always @(posedge clk) begin
    if (frame_err === 1'b1) err_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Clock out bits hi..lo of d, MSB first, mode 0.
  task automatic spi_bits(input logic [31:0] d, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      sdi = d[i];
      tick(2);
      sck = 1'b1;
      tick(2);
      sck = 1'b0;
    end
  endtask

  task automatic spi_shift(input logic [31:0] d, input int n);
    cs = 1'b0;
    tick(3);
    spi_bits(d, n - 1, 0);
    tick(2);
  endtask

  // Release cs and stop in the CHECK cycle (3 negedges later).
  task automatic cs_release();
    cs = 1'b1;
    tick(3);
  endtask

  task automatic send_frame(input logic [15:0] d);
    spi_shift({16'h0, d}, 16);
    cs_release();
    tick(3);
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    check(tag, {16'h0, frame_data}, {16'h0, exp});
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
  endtask

  initial begin
    int base;
    reset = 1'b1; sck = 1'b0; sdi = 1'b0; cs = 1'b1; frame_ready = 1'b0;
    tick(3);
    check("rst_valid", {31'h0, frame_valid}, 32'h0);
    check("rst_level", {29'h0, fifo_level}, 32'h0);
    check("rst_ovf",   {31'h0, overflow}, 32'h0);
    check("rst_busy",  {31'h0, busy}, 32'h0);
    check("rst_data",  {16'h0, frame_data}, 32'h0);
    reset = 1'b0;
    tick(2);

    // frame_ready on an empty FIFO must do nothing
    frame_ready = 1'b1;
    tick(2);
    frame_ready = 1'b0;
    check("empty_ready_level", {29'h0, fifo_level}, 32'h0);

    // Good frame and its exact latency
    spi_shift(32'h0000_A53C, 16);
    cs_release();
    check("good_busy_check", {31'h0, busy}, 32'h1);
    check("good_valid_early", {31'h0, frame_valid}, 32'h0);
    tick(1);
    check("good_valid", {31'h0, frame_valid}, 32'h1);
    check("good_data", {16'h0, frame_data}, 32'h0000_A53C);
    check("good_level", {29'h0, fifo_level}, 32'h1);
    check("good_err", {31'h0, frame_err}, 32'h0);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    check("good_pop_valid", {31'h0, frame_valid}, 32'h0);
    check("good_pop_level", {29'h0, fifo_level}, 32'h0);
    tick(2);
    check("good_busy_idle", {31'h0, busy}, 32'h0);

    // Length errors: 15, 17 and 0 bits
    base = err_pulses;
    spi_shift(32'h0000_7FFF, 15);
    cs_release();
    tick(1);
    check("len15_err", {31'h0, frame_err}, 32'h1);
    tick(1);
    check("len15_err_drop", {31'h0, frame_err}, 32'h0);
    tick(2);
    spi_shift(32'h0001_5555, 17);
    cs_release();
    tick(1);
    check("len17_err", {31'h0, frame_err}, 32'h1);
    tick(3);
    spi_shift(32'h0, 0);
    cs_release();
    tick(1);
    check("len0_err", {31'h0, frame_err}, 32'h1);
    tick(3);
    check("len_err_pulses", err_pulses - base, 32'd3);
    check("len_level", {29'h0, fifo_level}, 32'h0);
    check("len_valid", {31'h0, frame_valid}, 32'h0);

    // Overflow with frame_ready held low
    for (int i = 1; i <= 4; i++) send_frame(16'(i));
    check("ovf_level4", {29'h0, fifo_level}, 32'h4);
    check("ovf_not_yet", {31'h0, overflow}, 32'h0);
    send_frame(16'h0005);
    check("ovf_level_after5", {29'h0, fifo_level}, 32'h4);
    check("ovf_set", {31'h0, overflow}, 32'h1);
    pop_check("ovf_drain1", 16'h0001);
    pop_check("ovf_drain2", 16'h0002);
    pop_check("ovf_drain3", 16'h0003);
    pop_check("ovf_drain4", 16'h0004);
    check("ovf_empty", {29'h0, fifo_level}, 32'h0);
    check("ovf_sticky", {31'h0, overflow}, 32'h1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("ovf_cleared", {31'h0, overflow}, 32'h0);

    // Full FIFO with a pop in the CHECK cycle of the incoming frame
    send_frame(16'h1111);
    send_frame(16'h2222);
    send_frame(16'h3333);
    send_frame(16'h4444);
    spi_shift(32'h0000_5555, 16);
    cs_release();
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    check("cc_level", {29'h0, fifo_level}, 32'h4);
    check("cc_ovf", {31'h0, overflow}, 32'h0);
    pop_check("cc_drain1", 16'h2222);
    pop_check("cc_drain2", 16'h3333);
    pop_check("cc_drain3", 16'h4444);
    pop_check("cc_drain4", 16'h5555);
    check("cc_empty", {29'h0, fifo_level}, 32'h0);

    // Reset in the middle of a frame with two frames queued
    send_frame(16'hAAAA);
    send_frame(16'h5A5A);
    check("mid_level_pre", {29'h0, fifo_level}, 32'h2);
    cs = 1'b0;
    tick(3);
    spi_bits(32'h0000_BEEF, 15, 7);
    base = err_pulses;
    reset = 1'b1;
    tick(1);
    check("mid_level", {29'h0, fifo_level}, 32'h0);
    check("mid_valid", {31'h0, frame_valid}, 32'h0);
    check("mid_busy", {31'h0, busy}, 32'h0);
    check("mid_err", {31'h0, frame_err}, 32'h0);
    reset = 1'b0;
    check("mid_no_err_pulse", err_pulses - base, 32'd0);
    spi_bits(32'h0000_BEEF, 6, 0);
    tick(2);
    cs_release();
    tick(3);
    check("mid_remnant_level", {29'h0, fifo_level}, 32'h0);
    send_frame(16'hBEEF);
    check("mid_beef_level", {29'h0, fifo_level}, 32'h1);
    pop_check("mid_beef_data", 16'hBEEF);

    // Back-to-back frames with a short cs-high gap
    base = err_pulses;
    spi_shift(32'h0000_CAFE, 16);
    cs = 1'b1;
    tick(4);
    spi_shift(32'h0000_1234, 16);
    cs_release();
    tick(3);
    check("b2b_level", {29'h0, fifo_level}, 32'h2);
    check("b2b_no_err", err_pulses - base, 32'd0);
    pop_check("b2b_first", 16'hCAFE);
    pop_check("b2b_second", 16'h1234);
    check("b2b_empty", {31'h0, frame_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
- Parametrised successor to the MCU-facing SPI receive top.
- Synchronises the MCU SPI pins (sck, sdi, cs) into the clk domain and assembles fixed-length multi-byte frames.
- Validates frame length at chip-select release and buffers good frames in a FIFO.
- Presents frames to the downstream command decoder over a valid/ready handshake, with error and overflow reporting.

Parameters:
- PACKET_BYTES, 2, bytes per frame; frame width FW = 8*PACKET_BYTES.
- FIFO_DEPTH, 4, frames buffered; power of two, >= 2.
- SYNC_STAGES, 2, flip-flop stages per pin synchroniser; >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sck  input  1  async SPI clock from MCU, mode 0.
- sdi  input  1  async SPI data from MCU, MSB first.
- cs  input  1  async chip select, active low.
- frame_data  output  FW  head-of-FIFO frame; first received byte in the MSBs.
- frame_valid  output  1  FIFO non-empty.
- frame_ready  input  1  consumer accepts frame_data this cycle.
- frame_err  output  1  one-cycle pulse: a frame was discarded for bad length.
- overflow  output  1  sticky: a good frame was dropped because the FIFO was full.
- fifo_level  output  $clog2(FIFO_DEPTH+1)  frames currently stored.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (synchronous, active high):
  - All outputs go to 0.
  - FIFO is emptied; pointers and level are zeroed.
  - FSM goes to IDLE; shift register and bit counter are cleared.
  - Synchroniser chains load their idle values: sck=0, sdi=0, cs=1.
  - Reset asserted mid-frame discards the partial frame, raises no frame_err, and keeps no FIFO contents.
- Synchronisation and edge detection:
  - Each pin passes through SYNC_STAGES flops.
  - sck rising edge = sckSync & ~sckPrev, where sckPrev is sckSync registered once more.
- FSM states: IDLE, SHIFT, CHECK.
  - IDLE: when csSync==0, go to SHIFT and clear the bit counter.
  - SHIFT:
    - On each sck rising edge: shift register <= {shift[FW-2:0], sdiSync}; bit counter increments.
    - The bit counter saturates at FW+1, so any overlength frame is flagged.
    - When csSync==1, go to CHECK.
  - CHECK (exactly one cycle), then go to IDLE:
    - If bit count == FW, push the shift register into the FIFO.
    - Otherwise pulse frame_err and push nothing.
    - A zero-bit frame (cs low then high with no sck) is a length error.
- Latency: cs first seen high in SHIFT at cycle N -> CHECK at N+1 -> frame visible (frame_valid=1, level updated) at N+2.
- FIFO:
  - frame_data, frame_valid and fifo_level are registered-state derived, with no combinational path from frame_ready.
  - Pop occurs when frame_valid && frame_ready; frame_ready while empty is ignored.
  - Push succeeds if level < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A push attempt that cannot succeed drops the new frame, sets overflow (held until reset), and leaves stored frames untouched.
  - Simultaneous push and pop leaves the level unchanged.
  - Frames are delivered in arrival order; pointers wrap modulo FIFO_DEPTH.
- sck edges while in IDLE or CHECK are ignored.
- cs glitches shorter than SYNC_STAGES cycles are not filtered; the resulting short frames are reported through frame_err.

Test Plan:
- Good frame: PACKET_BYTES=2; send 0xA5,0x3C (16 sck edges) then raise cs -> frame_valid rises 2 cycles after csSync high; frame_data=16'hA53C; fifo_level=1; frame_err stays 0; pulse frame_ready -> frame_valid=0, level=0.
- Length errors: frame of 15 bits, then 17 bits, then 0 bits -> three single-cycle frame_err pulses; fifo_level stays 0; frame_valid never asserts.
- Overflow: frame_ready held 0; send frames 0x0001..0x0005 -> level=4 and overflow=1 after frame 5; drain -> 0x0001,0x0002,0x0003,0x0004 in order; overflow stays 1 until reset.
- Full with concurrent pop: FIFO full (0x1111..0x4444); frame_ready=1 exactly in the CHECK cycle of incoming 0x5555 -> 0x1111 popped, 0x5555 stored, level stays 4, overflow=0.
- Reset mid-frame: assert reset after 9 bits of a frame with 2 frames queued -> next cycle: level=0, frame_valid=0, busy=0, no frame_err. Finish the clocking; a subsequent clean 0xBEEF frame is received correctly.
- Back-to-back frames: cs high for SYNC_STAGES+2 cycles between 0xCAFE and 0x1234 -> both queued in order; no frame_err.
